vga_sync: RTL
=============

# vga_sync

Display-timing generator for the ping-pong display path: divides the system clock into a pixel tick and runs horizontal/vertical counters for 640x480 at 60 Hz. It drives `pixel_x`/`pixel_y` to the object renderer and text overlay, and `hsync`/`vsync`/`video_on` to the RGB mux. It also drives the two once-per-frame update strobes that gate object position updates in the object controller.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; must be ≥ 2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `DLY`, 16: delay of the second update strobe, in clk cycles.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `pixel_tick`  out  1  one-clk pulse every `CLK_DIV` clks; the counters advance on it.
- `pixel_x`  out  10  horizontal count, 0..799.
- `pixel_y`  out  10  vertical count, 0..524.
- `video_on`  out  1  high inside the visible area.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `update_allow_frist_pluse`  out  1  one-clk strobe at the start of vertical blanking.
- `update_allow_first_pluse_16dly`  out  1  the same strobe delayed by `DLY` clks.
- `frame_cnt`  out  8  frame counter; present only with `VGA_SYNC_FRAME_CNT_EN`.

## Operation
- Derived totals:
  - `H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK` = 800.
  - `V_TOTAL` = 525, built the same way.
- Divider:
  - Counts 0..`CLK_DIV`-1 and wraps.
  - `pixel_tick` = (div == `CLK_DIV`-1).
- Horizontal counter (`pixel_x`):
  - Increments on each `pixel_tick`.
  - Wraps from `H_TOTAL`-1 to 0.
- Vertical counter (`pixel_y`):
  - Increments only on the tick where `pixel_x` wraps.
  - Wraps from `V_TOTAL`-1 to 0.
- Output decode (combinational from the registered counters):
  - `video_on` = `pixel_x` < `H_DISPLAY` and `pixel_y` < `V_DISPLAY`.
  - `hsync` = 0 iff `pixel_x` is in [656, 751].
  - `vsync` = 0 iff `pixel_y` is in [490, 491].
- First strobe (`update_allow_frist_pluse`):
  - Registered; high for exactly one clk.
  - Fires on the first clk in which (`pixel_x`, `pixel_y`) == (0, `V_DISPLAY`).
  - That state lasts `CLK_DIV` clks; only its first clk produces the strobe.
- Delayed strobe (`update_allow_first_pluse_16dly`):
  - Produced by a `DLY`-stage shift register on the first strobe.
  - Its only job is to give the controller a second update phase within the same blanking period.
- Counter arithmetic: 10-bit unsigned. No value outside the ranges above may ever appear.

## Timing
- Reset values (while `rst` = 0):
  - div = 0, `pixel_tick` = 0.
  - `pixel_x` = 0, `pixel_y` = 0.
  - `hsync` = 1, `vsync` = 1, `video_on` = 1.
  - Both strobes 0, shift register cleared, `frame_cnt` = 0.
- After `rst` deasserts:
  - First `pixel_tick` on the `CLK_DIV`-th clk edge.
  - `pixel_x` reads 1 on the following clk.
- Period of `hsync`, `video_on` row and strobes:
  - Line = `H_TOTAL`·`CLK_DIV` = 1600 clks.
  - Frame = 840000 clks.
  - Strobe period = 840000 clks; the two strobes are exactly `DLY` clks apart.
- Sync widths:
  - hsync low for 96 pixels = 192 clks.
  - vsync low for 2 lines = 3200 clks.
- Reset asserted mid-frame: all state clears immediately (asynchronous). Any strobe pending in the delay line is discarded and never emitted.
- Line wrap and frame wrap occur on the same tick at (799, 524) → (0, 0); there is no extra cycle.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined:
  - 8-bit `frame_cnt` port exists.
  - Increments on the same clk edge that raises `update_allow_frist_pluse`.
  - Wraps from 255 to 0.
- `VGA_SYNC_FRAME_CNT_EN` undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, `CLK_DIV`=2 → `pixel_tick` high on clk 2 (clk 1 = first edge after release), `pixel_x`=1 from clk 3; `hsync`/`vsync`/`video_on` = 1.
- Free run, one line → `hsync` falls when `pixel_x` = 656 and stays low 192 clks; `video_on` low while `pixel_x` is in 640..799; line period 1600 clks.
- Free run, one frame → `vsync` low exactly while `pixel_y` is in 490..491 (3200 clks); `pixel_y` wraps 524 → 0 together with `pixel_x` 799 → 0.
- Strobes → one-clk `update_allow_frist_pluse` at (0, 480), `update_allow_first_pluse_16dly` exactly 16 clks later, both repeating every 840000 clks.
- Reset pulse 5 clks after the first strobe → delayed strobe never appears; counters restart from (0, 0).
- With `VGA_SYNC_FRAME_CNT_EN`, run 3 frames → `frame_cnt` = 3; force to 255, next strobe → 0.

Source files
------------

// File: rtl/vga_sync.sv
// 640x480@60 display-timing generator: pixel divider, h/v counters, sync decode and
// once-per-frame update strobes. Optional frame counter enabled by VGA_SYNC_FRAME_CNT_EN.
module vga_sync #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int DLY       = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       update_allow_frist_pluse,
  output logic       update_allow_first_pluse_16dly
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] V_VIS_M1 = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             tick_reg, tick_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic             strobe_reg, strobe_next;
  logic [DLY-1:0]   dly_reg, dly_next;

  // Tick is registered, so it lands one clk after the divider reaches its last count.
  always_comb begin
    div_next  = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    tick_next = (div_reg == DIV_LAST);
  end

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (tick_reg) begin
      if (x_reg == H_LAST) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  // Raised on the edge that moves the counters onto (0, V_DISPLAY): the state's first clk.
  always_comb begin
    strobe_next = tick_reg && (x_reg == H_LAST) && (y_reg == V_VIS_M1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DLY; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        assign dly_next[gi] = strobe_reg;
      end else begin : g_tail
        assign dly_next[gi] = dly_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg    <= '0;
      tick_reg   <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      strobe_reg <= 1'b0;
      dly_reg    <= '0;
    end else begin
      div_reg    <= div_next;
      tick_reg   <= tick_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      strobe_reg <= strobe_next;
      dly_reg    <= dly_next;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_reg, frame_next;

  always_comb begin
    frame_next = strobe_next ? frame_reg + 8'd1 : frame_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_reg <= '0;
    end else begin
      frame_reg <= frame_next;
    end
  end

  assign frame_cnt = frame_reg;
`endif

  assign pixel_tick                     = tick_reg;
  assign pixel_x                        = x_reg;
  assign pixel_y                        = y_reg;
  assign video_on                       = (x_reg < H_VIS) && (y_reg < V_VIS);
  assign hsync                          = !((x_reg >= HS_FIRST) && (x_reg <= HS_LAST));
  assign vsync                          = !((y_reg >= VS_FIRST) && (y_reg <= VS_LAST));
  assign update_allow_frist_pluse       = strobe_reg;
  assign update_allow_first_pluse_16dly = dly_reg[DLY-1];

endmodule
